// File: rtl/pps_mem_access.sv
// -----------------------------------------------------------------------------
// pps_mem_access
//   Memory stage between execute and writeback. Takes the execute stage's
//   memory request and runs a multi-cycle access on an external asynchronous
//   SRAM, holding the pipeline while the access is in flight. Load data is
//   lane-selected and sign/zero-extended, then registered for writeback.
//   Non-memory results pass straight through with one cycle of latency.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   MEM_req_in                 memory operation present
//   MEM_wr_in                  1 = store, 0 = load
//   MEM_addr_in                byte address
//   MEM_wdata_in/MEM_bwe_in    lane-aligned store data and byte enables
//   MEM_memop_type_in          access size (NULL/WORD/HWORD/BYTE)
//   MEM_unsigned_in            zero-extend load
//   MEM_ALUOut_in              non-load result
//   MEM_inst_rd_in             destination register
//   MEM_RegWrite_in            register write enable
//   MEM_stall_out              hold upstream pipeline
//   sram_*                     SRAM address, active-low strobes, data bus
//   WB_data_out/WB_inst_rd_out/WB_RegWrite_out   writeback outputs
// -----------------------------------------------------------------------------
`ifndef tMEM_OP_NULL
`define tMEM_OP_NULL  7'd0
`endif
`ifndef tMEM_OP_WORD
`define tMEM_OP_WORD  7'd1
`endif
`ifndef tMEM_OP_HWORD
`define tMEM_OP_HWORD 7'd2
`endif
`ifndef tMEM_OP_BYTE
`define tMEM_OP_BYTE  7'd3
`endif

module pps_mem_access #(
    parameter int unsigned WAIT_STATES      = 1,
    parameter int unsigned SRAM_ADDR_WIDTH  = 18,
    parameter int unsigned MEM_OP_TYPE_SIZE = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        MEM_req_in,
    input  logic                        MEM_wr_in,
    input  logic [31:0]                 MEM_addr_in,
    input  logic [31:0]                 MEM_wdata_in,
    input  logic [3:0]                  MEM_bwe_in,
    input  logic [MEM_OP_TYPE_SIZE-1:0] MEM_memop_type_in,
    input  logic                        MEM_unsigned_in,
    input  logic [31:0]                 MEM_ALUOut_in,
    input  logic [4:0]                  MEM_inst_rd_in,
    input  logic                        MEM_RegWrite_in,
    output logic                        MEM_stall_out,
    output logic [SRAM_ADDR_WIDTH-1:0]  sram_addr_out,
    output logic                        sram_ce_n_out,
    output logic                        sram_oe_n_out,
    output logic                        sram_we_n_out,
    output logic [3:0]                  sram_be_n_out,
    output logic [31:0]                 sram_dq_out,
    output logic                        sram_dq_oe_out,
    input  logic [31:0]                 sram_dq_in,
    output logic [31:0]                 WB_data_out,
    output logic [4:0]                  WB_inst_rd_out,
    output logic                        WB_RegWrite_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    state_e                        state_q;
    logic [3:0]                    cnt_q;
    logic                          wr_q;
    logic [1:0]                    off_q;
    logic [MEM_OP_TYPE_SIZE-1:0]   op_q;
    logic                          uns_q;
    logic [31:0]                   alu_q;
    logic [4:0]                    rd_q;
    logic                          rw_q;
    logic [31:0]                   rdata_q;

    logic [SRAM_ADDR_WIDTH-1:0]    sram_addr_q;
    logic                          ce_n_q;
    logic                          oe_n_q;
    logic                          we_n_q;
    logic [3:0]                    be_n_q;
    logic [31:0]                   dq_q;
    logic                          dq_oe_q;
    logic [31:0]                   wb_data_q;
    logic [4:0]                    wb_rd_q;
    logic                          wb_rw_q;

    // Upper byte-address bits beyond the SRAM window are not decoded.
    logic unused_addr_s;
    assign unused_addr_s = ^MEM_addr_in[31:SRAM_ADDR_WIDTH+2];

    // Little-endian lane select plus sign/zero extension of the raw SRAM word.
    function automatic logic [31:0] align_load(
        input logic [31:0]                 dq,
        input logic [1:0]                  off,
        input logic [MEM_OP_TYPE_SIZE-1:0] op,
        input logic                        uns
    );
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = off[1] ? dq[31:16] : dq[15:0];
        case (off)
            2'd0:    b = dq[7:0];
            2'd1:    b = dq[15:8];
            2'd2:    b = dq[23:16];
            2'd3:    b = dq[31:24];
            default: b = dq[7:0];
        endcase
        case (op)
            `tMEM_OP_NULL,
            `tMEM_OP_WORD:  r = dq;
            `tMEM_OP_HWORD: r = {{16{h[15] & ~uns}}, h};
            `tMEM_OP_BYTE:  r = {{24{b[7] & ~uns}}, b};
            default:        r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Stall is combinational so a new request freezes upstream in its own
    // cycle; it is forced low while reset is asserted.
    assign MEM_stall_out = rst_n & (((state_q == ST_IDLE) & MEM_req_in) |
                                    (state_q == ST_ACCESS));

    // Access FSM with all SRAM strobes and writeback outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            off_q       <= 2'd0;
            op_q        <= '0;
            uns_q       <= 1'b0;
            alu_q       <= 32'h0000_0000;
            rd_q        <= 5'd0;
            rw_q        <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 4'b1111;
            dq_q        <= 32'h0000_0000;
            dq_oe_q     <= 1'b0;
            wb_data_q   <= 32'h0000_0000;
            wb_rd_q     <= 5'd0;
            wb_rw_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (MEM_req_in) begin
                        wr_q        <= MEM_wr_in;
                        off_q       <= MEM_addr_in[1:0];
                        op_q        <= MEM_memop_type_in;
                        uns_q       <= MEM_unsigned_in;
                        alu_q       <= MEM_ALUOut_in;
                        rd_q        <= MEM_inst_rd_in;
                        rw_q        <= MEM_RegWrite_in;
                        sram_addr_q <= MEM_addr_in[SRAM_ADDR_WIDTH+1:2];
                        // Loads read the whole word; lanes are picked afterwards.
                        be_n_q      <= MEM_wr_in ? ~MEM_bwe_in : 4'b0000;
                        dq_q        <= MEM_wdata_in;
                        cnt_q       <= WAIT_CNT;
                        ce_n_q      <= 1'b0;
                        oe_n_q      <= MEM_wr_in;
                        we_n_q      <= ~MEM_wr_in;
                        dq_oe_q     <= MEM_wr_in;
                        wb_rw_q     <= 1'b0;
                        state_q     <= ST_ACCESS;
                    end else begin
                        wb_data_q   <= MEM_ALUOut_in;
                        wb_rd_q     <= MEM_inst_rd_in;
                        wb_rw_q     <= MEM_RegWrite_in;
                    end
                end
                ST_ACCESS: begin
                    wb_rw_q <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        if (!wr_q) begin
                            rdata_q <= sram_dq_in;
                        end
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        // dq_oe stays asserted through DONE to hold store data
                        // past the rising edge of we_n.
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    // Any request seen here is the instruction just completed.
                    wb_data_q <= wr_q ? alu_q : align_load(rdata_q, off_q, op_q, uns_q);
                    wb_rd_q   <= rd_q;
                    wb_rw_q   <= rw_q;
                    dq_oe_q   <= 1'b0;
                    be_n_q    <= 4'b1111;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sram_addr_out   = sram_addr_q;
    assign sram_ce_n_out   = ce_n_q;
    assign sram_oe_n_out   = oe_n_q;
    assign sram_we_n_out   = we_n_q;
    assign sram_be_n_out   = be_n_q;
    assign sram_dq_out     = dq_q;
    assign sram_dq_oe_out  = dq_oe_q;
    assign WB_data_out     = wb_data_q;
    assign WB_inst_rd_out  = wb_rd_q;
    assign WB_RegWrite_out = wb_rw_q;

endmodule

// File: tb/tb_pps_mem_access.sv
// -----------------------------------------------------------------------------
// tb_pps_mem_access
//   Directed self-checking bench for pps_mem_access (WAIT_STATES = 1).
//   Inputs change and outputs are sampled around the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pps_mem_access;

    localparam logic [6:0] OP_NULL  = 7'd0;
    localparam logic [6:0] OP_WORD  = 7'd1;
    localparam logic [6:0] OP_HWORD = 7'd2;
    localparam logic [6:0] OP_BYTE  = 7'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_req_in, MEM_wr_in, MEM_unsigned_in, MEM_RegWrite_in;
    logic [31:0] MEM_addr_in, MEM_wdata_in, MEM_ALUOut_in;
    logic [3:0]  MEM_bwe_in;
    logic [6:0]  MEM_memop_type_in;
    logic [4:0]  MEM_inst_rd_in;
    logic        MEM_stall_out;
    logic [17:0] sram_addr_out;
    logic        sram_ce_n_out, sram_oe_n_out, sram_we_n_out, sram_dq_oe_out;
    logic [3:0]  sram_be_n_out;
    logic [31:0] sram_dq_out, sram_dq_in;
    logic [31:0] WB_data_out;
    logic [4:0]  WB_inst_rd_out;
    logic        WB_RegWrite_out;

    int checks   = 0;
    int failures = 0;

    // Results recorded by run_access
    int          r_stall, r_oe, r_we;
    logic [3:0]  r_be;
    logic [17:0] r_addr;
    logic [31:0] r_dq;
    logic        r_done, r_done_dqoe, r_done_rw, r_rw_during;
    logic [31:0] r_wbd;
    logic [4:0]  r_wbrd;
    logic        r_wbrw;

    // Load extension vectors, dq_in = 0x80FF_1234
    localparam logic [31:0] EXT_ADDR [0:7] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h1, 32'h2, 32'h7, 32'h0};
    localparam logic [6:0]  EXT_OP   [0:7] = '{OP_BYTE, OP_BYTE, OP_HWORD, OP_HWORD, OP_BYTE, 7'd5, OP_WORD, OP_NULL};
    localparam logic        EXT_UNS  [0:7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [31:0] EXT_EXP  [0:7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_1234,
                                               32'h0000_0012, 32'h0000_0000, 32'h80FF_1234, 32'h80FF_1234};

    pps_mem_access #(
        .WAIT_STATES(1), .SRAM_ADDR_WIDTH(18), .MEM_OP_TYPE_SIZE(7)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_req_in(MEM_req_in), .MEM_wr_in(MEM_wr_in), .MEM_addr_in(MEM_addr_in),
        .MEM_wdata_in(MEM_wdata_in), .MEM_bwe_in(MEM_bwe_in),
        .MEM_memop_type_in(MEM_memop_type_in), .MEM_unsigned_in(MEM_unsigned_in),
        .MEM_ALUOut_in(MEM_ALUOut_in), .MEM_inst_rd_in(MEM_inst_rd_in),
        .MEM_RegWrite_in(MEM_RegWrite_in), .MEM_stall_out(MEM_stall_out),
        .sram_addr_out(sram_addr_out), .sram_ce_n_out(sram_ce_n_out),
        .sram_oe_n_out(sram_oe_n_out), .sram_we_n_out(sram_we_n_out),
        .sram_be_n_out(sram_be_n_out), .sram_dq_out(sram_dq_out),
        .sram_dq_oe_out(sram_dq_oe_out), .sram_dq_in(sram_dq_in),
        .WB_data_out(WB_data_out), .WB_inst_rd_out(WB_inst_rd_out),
        .WB_RegWrite_out(WB_RegWrite_out)
    );

    always #5 clk = ~clk;

    task automatic idle_cycle();
        MEM_req_in      = 1'b0;
        MEM_RegWrite_in = 1'b0;
        @(negedge clk);
    endtask

    // Present one request at the current negedge and follow it to DONE,
    // recording strobe activity; returns one cycle after DONE with req low.
    task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] bwe, input logic [6:0] op, input logic uns,
                              input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        MEM_req_in = 1'b1; MEM_wr_in = wr; MEM_addr_in = addr; MEM_wdata_in = wdata;
        MEM_bwe_in = bwe; MEM_memop_type_in = op; MEM_unsigned_in = uns;
        MEM_ALUOut_in = alu; MEM_inst_rd_in = rd; MEM_RegWrite_in = rw;
        r_stall = 0; r_oe = 0; r_we = 0; r_be = 4'hx; r_addr = 18'hx; r_dq = 32'hx;
        r_done = 1'b0; r_done_dqoe = 1'b0; r_done_rw = 1'b0; r_rw_during = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!r_done) begin
                #1;
                if (MEM_stall_out) r_stall++;
                if (!sram_oe_n_out) r_oe++;
                if (!sram_we_n_out) r_we++;
                if (!sram_ce_n_out) begin
                    r_be = sram_be_n_out; r_addr = sram_addr_out; r_dq = sram_dq_out;
                end
                if (c > 0 && MEM_stall_out && WB_RegWrite_out) r_rw_during = 1'b1;
                if (c > 0 && !MEM_stall_out) begin
                    r_done = 1'b1; r_done_dqoe = sram_dq_oe_out; r_done_rw = WB_RegWrite_out;
                end
                @(negedge clk);
            end
        end
        MEM_req_in = 1'b0;
        #1;
        r_wbd = WB_data_out; r_wbrd = WB_inst_rd_out; r_wbrw = WB_RegWrite_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        MEM_req_in = 1'b0; MEM_wr_in = 1'b0; MEM_addr_in = 32'h0; MEM_wdata_in = 32'h0;
        MEM_bwe_in = 4'h0; MEM_memop_type_in = OP_NULL; MEM_unsigned_in = 1'b0;
        MEM_ALUOut_in = 32'hFFFF_FFFF; MEM_inst_rd_in = 5'd31; MEM_RegWrite_in = 1'b1;
        sram_dq_in = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({MEM_stall_out, sram_ce_n_out, sram_oe_n_out, sram_we_n_out, sram_be_n_out, sram_dq_oe_out} !== 9'b0_111_1111_0) begin
            failures++;
            $display("FAIL reset_strobes got=%b want=%b", {MEM_stall_out, sram_ce_n_out, sram_oe_n_out, sram_we_n_out, sram_be_n_out, sram_dq_oe_out}, 9'b0_111_1111_0);
        end
        checks++;
        if ({sram_addr_out, sram_dq_out} !== 50'h0) begin
            failures++;
            $display("FAIL reset_sram_bus got=%h/%h want=0/0", sram_addr_out, sram_dq_out);
        end
        checks++;
        if ({WB_data_out, WB_inst_rd_out, WB_RegWrite_out} !== 38'h0) begin
            failures++;
            $display("FAIL reset_wb got=%h/%0d/%b want=0/0/0", WB_data_out, WB_inst_rd_out, WB_RegWrite_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        MEM_RegWrite_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        logic st;
        MEM_req_in = 1'b0; MEM_ALUOut_in = 32'h1234_5678; MEM_inst_rd_in = 5'd5; MEM_RegWrite_in = 1'b1;
        #1; st = MEM_stall_out;
        @(negedge clk); #1; st = st | MEM_stall_out;
        checks++;
        if ({WB_data_out, WB_inst_rd_out, WB_RegWrite_out} !== {32'h1234_5678, 5'd5, 1'b1}) begin
            failures++;
            $display("FAIL passthrough_wb got=%h/%0d/%b want=12345678/5/1", WB_data_out, WB_inst_rd_out, WB_RegWrite_out);
        end
        checks++;
        if (st !== 1'b0) begin
            failures++;
            $display("FAIL passthrough_stall got=%b want=0", st);
        end
        idle_cycle();
    endtask

    task automatic test_word_load();
        idle_cycle();
        sram_dq_in = 32'hDEAD_BEEF;
        run_access(1'b0, 32'h0000_0104, 32'h0, 4'h0, OP_WORD, 1'b0, 32'h1111_1111, 5'd9, 1'b1);
        checks++;
        if (r_done !== 1'b1) begin failures++; $display("FAIL wload_timeout got=%b want=1", r_done); end
        checks++;
        if (r_stall !== 3) begin failures++; $display("FAIL wload_stall_cycles got=%0d want=3", r_stall); end
        checks++;
        if (r_oe !== 2 || r_we !== 0) begin failures++; $display("FAIL wload_oe_we got=%0d/%0d want=2/0", r_oe, r_we); end
        checks++;
        if (r_addr !== 18'h41 || r_be !== 4'b0000) begin failures++; $display("FAIL wload_addr_be got=%h/%b want=41/0000", r_addr, r_be); end
        checks++;
        if (r_done_rw !== 1'b0 || r_rw_during !== 1'b0) begin failures++; $display("FAIL wload_bubble got=%b/%b want=0/0", r_done_rw, r_rw_during); end
        checks++;
        if (r_done_dqoe !== 1'b0) begin failures++; $display("FAIL wload_dqoe got=%b want=0", r_done_dqoe); end
        checks++;
        if ({r_wbd, r_wbrd, r_wbrw} !== {32'hDEAD_BEEF, 5'd9, 1'b1}) begin
            failures++; $display("FAIL wload_wb got=%h/%0d/%b want=deadbeef/9/1", r_wbd, r_wbrd, r_wbrw);
        end
    endtask

    task automatic test_load_extend();
        sram_dq_in = 32'h80FF_1234;
        for (int i = 0; i < 8; i++) begin
            idle_cycle();
            run_access(1'b0, EXT_ADDR[i], 32'h0, 4'h0, EXT_OP[i], EXT_UNS[i], 32'h0, 5'd10, 1'b1);
            checks++;
            if (r_wbd !== EXT_EXP[i]) begin
                failures++; $display("FAIL load_ext_%0d got=%h want=%h", i, r_wbd, EXT_EXP[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        idle_cycle();
        run_access(1'b1, 32'h0000_0102, 32'h00AB_0000, 4'b0100, OP_BYTE, 1'b0, 32'h0000_0102, 5'd0, 1'b0);
        checks++;
        if (r_stall !== 3 || r_we !== 2 || r_oe !== 0) begin
            failures++; $display("FAIL store_strobes got=%0d/%0d/%0d want=3/2/0", r_stall, r_we, r_oe);
        end
        checks++;
        if (r_be !== 4'b1011 || r_dq !== 32'h00AB_0000 || r_addr !== 18'h40) begin
            failures++; $display("FAIL store_bus got=%b/%h/%h want=1011/00ab0000/40", r_be, r_dq, r_addr);
        end
        checks++;
        if (r_done_dqoe !== 1'b1) begin failures++; $display("FAIL store_dq_hold got=%b want=1", r_done_dqoe); end
        checks++;
        if (sram_dq_oe_out !== 1'b0) begin failures++; $display("FAIL store_dq_release got=%b want=0", sram_dq_oe_out); end
        checks++;
        if (r_wbrw !== 1'b0 || r_done_rw !== 1'b0) begin
            failures++; $display("FAIL store_regwrite got=%b/%b want=0/0", r_done_rw, r_wbrw);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  stall_v, ce_v, rw_v;
        logic [31:0] wb4, wb8;
        idle_cycle();
        sram_dq_in = 32'hCAFE_F00D;
        MEM_req_in = 1'b1; MEM_wr_in = 1'b0; MEM_addr_in = 32'h0000_0020; MEM_memop_type_in = OP_WORD;
        MEM_unsigned_in = 1'b0; MEM_inst_rd_in = 5'd7; MEM_RegWrite_in = 1'b1; MEM_ALUOut_in = 32'h0;
        stall_v = '0; ce_v = '0; rw_v = '0; wb4 = 32'h0; wb8 = 32'h0;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) MEM_req_in = 1'b0;
            #1;
            stall_v[c] = MEM_stall_out;
            ce_v[c]    = ~sram_ce_n_out;
            rw_v[c]    = WB_RegWrite_out;
            if (c == 4) wb4 = WB_data_out;
            if (c == 8) wb8 = WB_data_out;
            if (c < 8) @(negedge clk);
        end
        checks++;
        if (stall_v !== 9'h077) begin failures++; $display("FAIL b2b_stall got=%b want=%b", stall_v, 9'h077); end
        checks++;
        if (ce_v !== 9'h066) begin failures++; $display("FAIL b2b_accesses got=%b want=%b", ce_v, 9'h066); end
        checks++;
        if (rw_v !== 9'h110) begin failures++; $display("FAIL b2b_writebacks got=%b want=%b", rw_v, 9'h110); end
        checks++;
        if (wb4 !== 32'hCAFE_F00D || wb8 !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL b2b_data got=%h/%h want=cafef00d", wb4, wb8);
        end
    endtask

    task automatic test_reset_mid_access();
        int ce_low;
        idle_cycle();
        MEM_req_in = 1'b1; MEM_wr_in = 1'b1; MEM_addr_in = 32'h0000_0200; MEM_wdata_in = 32'h55AA_55AA;
        MEM_bwe_in = 4'hF; MEM_memop_type_in = OP_WORD; MEM_inst_rd_in = 5'd3; MEM_RegWrite_in = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (sram_we_n_out !== 1'b0 || sram_dq_oe_out !== 1'b1) begin
            failures++; $display("FAIL rstmid_in_access got=%b/%b want=0/1", sram_we_n_out, sram_dq_oe_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({MEM_stall_out, sram_we_n_out, sram_dq_oe_out, sram_ce_n_out, WB_RegWrite_out} !== 5'b01010) begin
            failures++; $display("FAIL rstmid_abort got=%b want=01010", {MEM_stall_out, sram_we_n_out, sram_dq_oe_out, sram_ce_n_out, WB_RegWrite_out});
        end
        @(negedge clk);
        MEM_req_in = 1'b0; MEM_RegWrite_in = 1'b0; rst_n = 1'b1;
        ce_low = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (!sram_ce_n_out || MEM_stall_out || WB_RegWrite_out) ce_low++;
        end
        checks++;
        if (ce_low !== 0) begin failures++; $display("FAIL rstmid_idle got=%0d want=0", ce_low); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_word_load();
        test_load_extend();
        test_byte_store();
        test_back_to_back();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pps_mem_access.md
Name: pps_mem_access

Overview:
- Memory-stage block between the execute stage and writeback. It sits at the other end of the execute stage's memory interface.
- It consumes the execute stage's memory request: address, byte-aligned store data, byte write enables and memop type.
- It runs a multi-cycle access to the external asynchronous SRAM and stalls the pipeline while the access is in flight.
- For loads, it extracts and sign- or zero-extends the addressed byte, halfword or word, then registers the result for writeback.

Parameters:
- WAIT_STATES, 1, extra SRAM access cycles; the ACCESS state lasts WAIT_STATES+1 cycles (range 0..15).
- SRAM_ADDR_WIDTH, 18, SRAM word-address width.
- MEM_OP_TYPE_SIZE, 7, memop type width; encodings use `tMEM_OP_NULL/WORD/HWORD/BYTE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MEM_req_in  in  1  memory operation present (memop).
- MEM_wr_in  in  1  1 = store, 0 = load.
- MEM_addr_in  in  32  byte address (execute ALU result).
- MEM_wdata_in  in  32  lane-aligned store data.
- MEM_bwe_in  in  4  store byte enables; bit n = byte lane n (bits 8n+7:8n).
- MEM_memop_type_in  in  MEM_OP_TYPE_SIZE  access size.
- MEM_unsigned_in  in  1  1 = zero-extend load (lbu/lhu).
- MEM_ALUOut_in  in  32  non-load result.
- MEM_inst_rd_in  in  5  destination register.
- MEM_RegWrite_in  in  1  register write enable.
- MEM_stall_out  out  1  hold upstream pipeline.
- sram_addr_out  out  SRAM_ADDR_WIDTH  word address.
- sram_ce_n_out, sram_oe_n_out, sram_we_n_out  out  1 each  active-low strobes.
- sram_be_n_out  out  4  active-low byte enables.
- sram_dq_out  out  32  write data.
- sram_dq_oe_out  out  1  tristate enable for dq.
- sram_dq_in  in  32  read data.
- WB_data_out  out  32  writeback data.
- WB_inst_rd_out  out  5  writeback destination.
- WB_RegWrite_out  out  1  writeback enable.

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - ce_n/oe_n/we_n = 1, be_n = 4'b1111, dq_oe = 0, sram_addr = 0, sram_dq_out = 0.
  - stall = 0, WB_* = 0.
  - Reset mid-access aborts the access with no writeback.
- FSM states IDLE, ACCESS, DONE.
- IDLE, MEM_req_in = 0:
  - No stall.
  - At the edge, WB_data <= MEM_ALUOut_in, WB_inst_rd <= MEM_inst_rd_in, WB_RegWrite <= MEM_RegWrite_in (1-cycle latency).
- IDLE, MEM_req_in = 1:
  - MEM_stall_out = 1 combinationally.
  - At the edge: capture wr, addr[1:0], type, unsigned, ALUOut, rd, RegWrite.
  - sram_addr <= addr[SRAM_ADDR_WIDTH+1:2].
  - be_n <= ~MEM_bwe_in for a store, 4'b0000 for a load.
  - sram_dq_out <= MEM_wdata_in.
  - cnt <= WAIT_STATES; WB_RegWrite <= 0; go to ACCESS.
- ACCESS:
  - stall = 1, ce_n = 0.
  - Load: oe_n = 0. Store: we_n = 0, dq_oe = 1.
  - cnt decrements each cycle.
  - When cnt == 0, a load captures sram_dq_in and the FSM goes to DONE.
  - WB_RegWrite is held at 0 (bubble).
- DONE:
  - stall = 0; ce_n/oe_n/we_n = 1.
  - dq_oe stays 1 for a store (data hold), 0 for a load.
  - At the edge: WB_data <= aligned load data (load) or captured ALUOut (store); WB_inst_rd and WB_RegWrite <= captured values; state <= IDLE.
  - MEM_req_in seen in DONE belongs to the completed instruction and is ignored.
- Timing for a request presented in cycle 0:
  - stall is high for cycles 0..WAIT_STATES+1 and low in DONE (cycle WAIT_STATES+2).
  - WB outputs are valid from cycle WAIT_STATES+3.
  - Back-to-back requests: the next request is accepted in IDLE, the cycle after DONE.
- Load alignment, little-endian lanes, matching the store alignment:
  - NULL/WORD: data unchanged.
  - HWORD: off[1] = 1 selects dq[31:16], else dq[15:0]; extend bit 15 unless unsigned.
  - BYTE: selects dq[8*off+7:8*off]; extend bit 7 unless unsigned.
  - Any other type code: 32'h0000_0000.
  - Misaligned word/halfword raises no exception; the low bits are ignored as above.

Test Plan:
- Non-memory passthrough: IDLE, req = 0, ALUOut = 0x1234_5678, rd = 5, RegWrite = 1 -> next cycle WB = 0x12345678/5/1; stall never high.
- Word load (WAIT_STATES = 1): addr = 0x0000_0104, dq_in = 0xDEADBEEF -> stall high 3 cycles; sram_addr = 0x41, oe_n low 2 cycles, be_n = 0000; WB_data = 0xDEADBEEF, WB_RegWrite = 1 one cycle after DONE, 0 before.
- Load extension with dq_in = 0x80FF_1234:
  - lb off 3 -> 0xFFFFFF80; lbu off 3 -> 0x00000080.
  - lh off 2 -> 0xFFFF80FF; lhu off 0 -> 0x00001234; lb off 1 -> 0x00000012.
- Byte store: addr offset 2, bwe = 0100, wdata = 0x00AB0000 -> we_n low 2 cycles, be_n = 1011, dq_out = 0x00AB0000; dq_oe high through DONE; WB_RegWrite = 0.
- Back-to-back loads with req held through DONE -> exactly two accesses; the second starts the cycle after DONE, with no duplicate writeback.
- rst_n low during ACCESS of a store -> immediately we_n = 1, dq_oe = 0, stall = 0, WB_RegWrite = 0; after release the FSM idles in IDLE.
